// File: rtl/fetch_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_ctrl_if
//  Purpose  : Loader, program-memory and decode-side signals of fetch_ctrl.
//             The master modport is the controller; the slave modport is the
//             environment (loader, memory, decode stage).
//  Revision : 1.0  initial release
// ============================================================================
interface fetch_ctrl_if #(
    parameter int AW = 5,
    parameter int DW = 32
);
    logic          ld_start;
    logic          ld_valid;
    logic [DW-1:0] ld_data;
    logic          ld_last;
    logic          ld_ready;
    logic          run_start;
    logic          br_taken;
    logic [AW-1:0] br_target;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic          mem_write;
    logic [DW-1:0] mem_rdata;
    logic [DW-1:0] inst;
    logic [AW-1:0] inst_pc;
    logic          inst_valid;
    logic          inst_ready;
    logic          halted;
    logic          busy;

    modport master (
        input  ld_start, ld_valid, ld_data, ld_last, run_start,
               br_taken, br_target, mem_rdata, inst_ready,
        output ld_ready, mem_addr, mem_wdata, mem_write,
               inst, inst_pc, inst_valid, halted, busy
    );

    modport slave (
        output ld_start, ld_valid, ld_data, ld_last, run_start,
               br_taken, br_target, mem_rdata, inst_ready,
        input  ld_ready, mem_addr, mem_wdata, mem_write,
               inst, inst_pc, inst_valid, halted, busy
    );
endinterface
`default_nettype wire

// File: rtl/fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_ctrl
//  Purpose  : Program counter / sequencer sharing the single instruction
//             memory port between the program loader and instruction fetch.
//             Supports load, run, branch redirect, stall and halt-on-opcode.
//  Revision : 1.0  initial release
// ============================================================================
module fetch_ctrl #(
    parameter int            AW        = 5,
    parameter int            DW        = 32,
    parameter logic [DW-1:0] HALT_WORD = 32'hFFFF_FFFF
) (
    input  wire logic    CLK,
    input  wire logic    RST,
    fetch_ctrl_if.master bus
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_HALT = 2'd3
    } state_t;

    localparam logic [AW-1:0] c_PTR_MAX = '1;

    state_t        r_state;
    logic [AW-1:0] r_pc;
    logic [AW-1:0] r_ld_ptr;
    logic [DW-1:0] r_inst;
    logic [AW-1:0] r_inst_pc;
    logic          r_inst_valid;

    // Output slot is free this cycle (empty, or being consumed).
    logic w_slot_free;
    // Word at pc is the halt opcode.
    logic w_halt_hit;

    assign w_slot_free = !r_inst_valid || bus.inst_ready;
    assign w_halt_hit  = (bus.mem_rdata == HALT_WORD);

    // Sequencer: state, pointers and the registered instruction slot.
    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state      <= ST_IDLE;
            r_pc         <= '0;
            r_ld_ptr     <= '0;
            r_inst       <= '0;
            r_inst_pc    <= '0;
            r_inst_valid <= 1'b0;
        end else begin
            unique case (r_state)
                ST_IDLE: begin
                    if (bus.ld_start) begin
                        r_state  <= ST_LOAD;
                        r_ld_ptr <= '0;
                    end else if (bus.run_start) begin
                        r_state <= ST_RUN;
                        r_pc    <= '0;
                    end
                end
                ST_LOAD: begin
                    if (bus.ld_valid) begin
                        // Pointer saturates at the top address; no wrap.
                        if (r_ld_ptr != c_PTR_MAX)
                            r_ld_ptr <= r_ld_ptr + 1'b1;
                        if (bus.ld_last || (r_ld_ptr == c_PTR_MAX))
                            r_state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (bus.br_taken) begin
                        // Redirect wins over fetch and flushes the slot.
                        r_pc         <= bus.br_target;
                        r_inst_valid <= 1'b0;
                    end else if (w_slot_free) begin
                        if (w_halt_hit) begin
                            // Halt opcode is never issued; pc holds on it.
                            r_state      <= ST_HALT;
                            r_inst_valid <= 1'b0;
                        end else begin
                            r_inst       <= bus.mem_rdata;
                            r_inst_pc    <= r_pc;
                            r_inst_valid <= 1'b1;
                            r_pc         <= r_pc + 1'b1;
                        end
                    end
                end
                ST_HALT: begin
                    if (bus.inst_ready)
                        r_inst_valid <= 1'b0;
                    if (bus.ld_start) begin
                        r_state      <= ST_LOAD;
                        r_ld_ptr     <= '0;
                        r_inst_valid <= 1'b0;
                    end else if (bus.run_start) begin
                        r_state      <= ST_RUN;
                        r_pc         <= '0;
                        r_inst_valid <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Memory port mux: loader owns it in LOAD, fetch owns it in RUN.
    always_comb begin
        bus.mem_addr  = '0;
        bus.mem_wdata = '0;
        bus.mem_write = 1'b0;
        unique case (r_state)
            ST_LOAD: begin
                bus.mem_addr = r_ld_ptr;
                // A reset cycle must not commit a loader word.
                if (bus.ld_valid && !RST) begin
                    bus.mem_wdata = bus.ld_data;
                    bus.mem_write = 1'b1;
                end
            end
            ST_RUN:  bus.mem_addr = r_pc;
            default: bus.mem_addr = '0;
        endcase
    end

    assign bus.ld_ready   = (r_state == ST_LOAD);
    assign bus.halted     = (r_state == ST_HALT);
    assign bus.busy       = (r_state == ST_LOAD) || (r_state == ST_RUN);
    assign bus.inst       = r_inst;
    assign bus.inst_pc    = r_inst_pc;
    assign bus.inst_valid = r_inst_valid;

endmodule
`default_nettype wire

// File: tb/tb_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_ctrl
//  Purpose  : Directed self-checking bench for fetch_ctrl with a 32x32
//             behavioural instruction memory.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fetch_ctrl;

    localparam logic [31:0] c_HALT = 32'hFFFF_FFFF;

    logic CLK = 1'b0;
    logic RST = 1'b1;

    fetch_ctrl_if #(.AW(5), .DW(32)) bus ();

    fetch_ctrl #(.AW(5), .DW(32), .HALT_WORD(c_HALT)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.master)
    );

    always #5 CLK = ~CLK;

    // Behavioural memory: combinational read, write on rising edge.
    logic [31:0] mem [32];
    int          wr_count = 0;
    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge CLK) begin
        if (bus.mem_write === 1'b1) begin
            mem[bus.mem_addr] <= bus.mem_wdata;
            wr_count          <= wr_count + 1;
        end
    end

    int vectors    = 0;
    int miscompares = 0;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, ".busy"},       {31'd0, bus.busy},       32'd0);
        chk({tag, ".halted"},     {31'd0, bus.halted},     32'd0);
        chk({tag, ".ld_ready"},   {31'd0, bus.ld_ready},   32'd0);
        chk({tag, ".inst_valid"}, {31'd0, bus.inst_valid}, 32'd0);
        chk({tag, ".inst"},       bus.inst,                32'd0);
        chk({tag, ".inst_pc"},    {27'd0, bus.inst_pc},    32'd0);
        chk({tag, ".mem_addr"},   {27'd0, bus.mem_addr},   32'd0);
        chk({tag, ".mem_wdata"},  bus.mem_wdata,           32'd0);
        chk({tag, ".mem_write"},  {31'd0, bus.mem_write},  32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] prog [4];
        prog[0] = 32'h11;
        prog[1] = 32'h22;
        prog[2] = 32'h33;
        prog[3] = c_HALT;

        bus.ld_start   = 1'b0;
        bus.ld_valid   = 1'b0;
        bus.ld_data    = '0;
        bus.ld_last    = 1'b0;
        bus.run_start  = 1'b0;
        bus.br_taken   = 1'b0;
        bus.br_target  = '0;
        bus.inst_ready = 1'b0;

        // Power-on reset.
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        chk_reset_outputs("por");

        // Load four words with gaps, last one flagged.
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        chk("load.ld_ready", {31'd0, bus.ld_ready}, 32'd1);
        chk("load.busy",     {31'd0, bus.busy},     32'd1);
        for (int i = 0; i < 4; i++) begin
            bus.ld_valid = 1'b0;
            tick();
            chk("load.gap_nowrite", {31'd0, bus.mem_write}, 32'd0);
            bus.ld_valid = 1'b1;
            bus.ld_data  = prog[i];
            bus.ld_last  = (i == 3);
            #1;
            chk("load.write", {31'd0, bus.mem_write}, 32'd1);
            chk("load.addr",  {27'd0, bus.mem_addr},  32'(i));
            chk("load.wdata", bus.mem_wdata,          prog[i]);
            tick();
            bus.ld_valid = 1'b0;
            bus.ld_last  = 1'b0;
        end
        chk("load.done_busy", {31'd0, bus.busy},     32'd0);
        chk("load.done_rdy",  {31'd0, bus.ld_ready}, 32'd0);
        chk("load.wr_count",  32'(wr_count),         32'd4);
        chk("load.mem0",      mem[0],                32'h11);
        chk("load.mem3",      mem[3],                c_HALT);

        // Run to the halt opcode.
        bus.run_start = 1'b1;
        tick();
        bus.run_start  = 1'b0;
        bus.inst_ready = 1'b1;
        chk("run.busy",       {31'd0, bus.busy},       32'd1);
        chk("run.first_inv",  {31'd0, bus.inst_valid}, 32'd0);
        chk("run.first_addr", {27'd0, bus.mem_addr},   32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("run.inst",    bus.inst,                prog[i]);
            chk("run.inst_pc", {27'd0, bus.inst_pc},    32'(i));
            chk("run.valid",   {31'd0, bus.inst_valid}, 32'd1);
        end
        tick();
        chk("halt.halted", {31'd0, bus.halted},     32'd1);
        chk("halt.valid",  {31'd0, bus.inst_valid}, 32'd0);
        chk("halt.busy",   {31'd0, bus.busy},       32'd0);

        // Branch in HALT is ignored.
        bus.br_taken  = 1'b1;
        bus.br_target = 5'd1;
        tick();
        bus.br_taken = 1'b0;
        chk("halt.br_ignored",  {31'd0, bus.halted},     32'd1);
        chk("halt.br_novalid",  {31'd0, bus.inst_valid}, 32'd0);
        chk("halt.br_nowrite",  32'(wr_count),           32'd4);

        // Restart; branch coinciding with the halt-word fetch keeps RUN.
        bus.run_start = 1'b1;
        tick();
        bus.run_start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("rerun.inst_pc", {27'd0, bus.inst_pc}, 32'(i));
        end
        bus.br_taken  = 1'b1;
        bus.br_target = 5'd1;
        tick();
        bus.br_taken = 1'b0;
        chk("brhalt.halted", {31'd0, bus.halted},     32'd0);
        chk("brhalt.busy",   {31'd0, bus.busy},       32'd1);
        chk("brhalt.flush",  {31'd0, bus.inst_valid}, 32'd0);
        tick();
        chk("brhalt.inst_pc", {27'd0, bus.inst_pc}, 32'd1);
        chk("brhalt.inst",    bus.inst,             32'h22);
        tick();
        chk("brhalt.inst_pc2", {27'd0, bus.inst_pc}, 32'd2);
        tick();
        chk("brhalt.halt_again", {31'd0, bus.halted}, 32'd1);

        // Full 32-word load without ld_last; other controls ignored mid-load.
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        for (int i = 0; i < 32; i++) begin
            bus.ld_valid = 1'b1;
            bus.ld_data  = 32'hA000 + 32'(i);
            if (i == 10) begin
                bus.run_start = 1'b1;
                bus.ld_start  = 1'b1;
                bus.br_taken  = 1'b1;
                bus.br_target = 5'd3;
            end
            #1;
            chk("full.addr",  {27'd0, bus.mem_addr},  32'(i));
            chk("full.write", {31'd0, bus.mem_write}, 32'd1);
            tick();
            bus.run_start = 1'b0;
            bus.ld_start  = 1'b0;
            bus.br_taken  = 1'b0;
            if (i == 10) begin
                chk("full.ign_busy",  {31'd0, bus.busy},     32'd1);
                chk("full.ign_ready", {31'd0, bus.ld_ready}, 32'd1);
            end
        end
        bus.ld_valid = 1'b0;
        chk("full.idle_busy", {31'd0, bus.busy},     32'd0);
        chk("full.idle_rdy",  {31'd0, bus.ld_ready}, 32'd0);
        chk("full.wr_count",  32'(wr_count),         32'd36);
        chk("full.mem10",     mem[10],               32'hA00A);
        chk("full.mem31",     mem[31],               32'hA01F);

        // Run and stall.
        bus.run_start = 1'b1;
        tick();
        bus.run_start  = 1'b0;
        bus.inst_ready = 1'b1;
        tick();
        chk("stall.pc0", {27'd0, bus.inst_pc}, 32'd0);
        chk("stall.i0",  bus.inst,             32'hA000);
        tick();
        chk("stall.pc1", {27'd0, bus.inst_pc}, 32'd1);
        bus.inst_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall.frozen_pc",   {27'd0, bus.inst_pc},    32'd1);
            chk("stall.frozen_inst", bus.inst,                32'hA001);
            chk("stall.frozen_addr", {27'd0, bus.mem_addr},   32'd2);
            chk("stall.valid",       {31'd0, bus.inst_valid}, 32'd1);
        end
        bus.inst_ready = 1'b1;
        tick();
        chk("stall.release_pc", {27'd0, bus.inst_pc}, 32'd2);

        // ld_start during RUN is ignored.
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        chk("run.ldstart_pc",    {27'd0, bus.inst_pc},   32'd3);
        chk("run.ldstart_busy",  {31'd0, bus.busy},      32'd1);
        chk("run.ldstart_rdy",   {31'd0, bus.ld_ready},  32'd0);
        chk("run.ldstart_write", {31'd0, bus.mem_write}, 32'd0);

        // Branch to 20 while holding an unconsumed instruction.
        bus.inst_ready = 1'b0;
        bus.br_taken   = 1'b1;
        bus.br_target  = 5'd20;
        tick();
        bus.br_taken = 1'b0;
        chk("br.flush", {31'd0, bus.inst_valid}, 32'd0);
        tick();
        chk("br.target_pc",   {27'd0, bus.inst_pc},    32'd20);
        chk("br.target_inst", bus.inst,                32'hA014);
        chk("br.valid",       {31'd0, bus.inst_valid}, 32'd1);

        // Stream through the top of memory and wrap.
        bus.inst_ready = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            tick();
            chk("wrap.inst_pc", {27'd0, bus.inst_pc}, 32'((20 + k) % 32));
        end

        // Reset held two cycles in the middle of RUN.
        RST = 1'b1;
        tick();
        tick();
        RST = 1'b0;
        chk_reset_outputs("rst_run");

        // Reset in the middle of LOAD suppresses that cycle's write.
        bus.ld_start = 1'b1;
        tick();
        bus.ld_start = 1'b0;
        bus.ld_valid = 1'b1;
        bus.ld_data  = 32'h5;
        RST = 1'b1;
        #1;
        chk("rst_load.nowrite", {31'd0, bus.mem_write}, 32'd0);
        tick();
        RST = 1'b0;
        bus.ld_valid = 1'b0;
        chk("rst_load.wr_count", 32'(wr_count),     32'd36);
        chk("rst_load.busy",     {31'd0, bus.busy}, 32'd0);
        chk("rst_load.mem0",     mem[0],            32'hA000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
